// File: rtl/motor_pkg.sv
// Shared types and constants for the shared step/dir motor scheduler.
package motor_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow
  } state_e;

  localparam logic       AXIS_THETA = 1'b0;
  localparam logic       AXIS_PHI   = 1'b1;
  localparam logic [1:0] REQ_ON     = 2'b01;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; zero marks the last cycle of a timed phase.
module step_timer #(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/motor_step_scheduler.sv
// Round-robin scheduler sharing one step/dir driver between the theta and phi axes,
// with timed pulses and position tracking (theta saturating, phi wrapping).
module motor_step_scheduler
  import motor_pkg::*;
#(
  parameter int unsigned W          = 16,
  parameter int unsigned SETUP_CYC  = 50,
  parameter int unsigned PULSE_CYC  = 100,
  parameter int unsigned STEP_CYC   = 1000,
  parameter int unsigned THETA_MAX  = 180,
  parameter int unsigned PHI_MAX    = 359,
  parameter int unsigned THETA_INIT = 90,
  parameter int unsigned PHI_INIT   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_theta_pos,
  input  logic [1:0]   req_theta_neg,
  input  logic [1:0]   req_phi_pos,
  input  logic [1:0]   req_phi_neg,
  output logic         drv_step,
  output logic         drv_dir,
  output logic         drv_sel,
  output logic         busy,
  output logic         theta_limit,
  output logic [W-1:0] theta_actual,
  output logic [W-1:0] phi_actual
);

  localparam int unsigned MAX_CYC = (SETUP_CYC > STEP_CYC) ? SETUP_CYC : STEP_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  // Timer loads are cycle counts minus one: the zero cycle is the last in the phase.
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] LOW_LOAD   = CW'(STEP_CYC - PULSE_CYC - 2);

  state_e        state_q, state_d;
  logic          sel_q, sel_d, dir_q, dir_d;
  logic          last_axis_q, last_dir_q;
  logic [W-1:0]  theta_q, phi_q;
  logic          load, zero, step_done;
  logic [CW-1:0] load_val;

  logic theta_pos_on, theta_neg_on, theta_valid, theta_blocked, theta_ok;
  logic phi_pos_on, phi_neg_on, phi_valid;
  logic grant_any, grant_phi, grant_dir, still_req;

  assign theta_pos_on  = (req_theta_pos == REQ_ON);
  assign theta_neg_on  = (req_theta_neg == REQ_ON);
  assign theta_valid   = theta_pos_on ^ theta_neg_on;
  assign theta_blocked = theta_valid &&
                         ((theta_pos_on && theta_q == W'(THETA_MAX)) ||
                          (theta_neg_on && theta_q == '0));
  assign theta_ok      = theta_valid && !theta_blocked;

  assign phi_pos_on = (req_phi_pos == REQ_ON);
  assign phi_neg_on = (req_phi_neg == REQ_ON);
  assign phi_valid  = phi_pos_on ^ phi_neg_on;

  // On a tie, the axis that did not step last wins.
  assign grant_any = theta_ok || phi_valid;
  assign grant_phi = phi_valid && (!theta_ok || last_axis_q == AXIS_THETA);
  assign grant_dir = grant_phi ? phi_pos_on : theta_pos_on;
  assign still_req = (sel_q == AXIS_PHI) ? (phi_valid && phi_pos_on == dir_q)
                                         : (theta_ok && theta_pos_on == dir_q);

  step_timer #(
    .CW(CW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .value(load_val),
    .zero (zero)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    dir_d     = dir_q;
    load      = 1'b0;
    load_val  = '0;
    step_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_any) begin
          sel_d = grant_phi;
          dir_d = grant_dir;
          load  = 1'b1;
          if (grant_phi == last_axis_q && grant_dir == last_dir_q) begin
            state_d  = StHigh;
            load_val = PULSE_LOAD;
          end else begin
            state_d  = StSetup;
            load_val = SETUP_LOAD;
          end
        end
      end
      StSetup: begin
        if (!still_req) begin
          state_d = StIdle;
        end else if (zero) begin
          state_d  = StHigh;
          load     = 1'b1;
          load_val = PULSE_LOAD;
        end
      end
      StHigh: begin
        if (zero) begin
          state_d   = StLow;
          load      = 1'b1;
          load_val  = LOW_LOAD;
          step_done = 1'b1;
        end
      end
      StLow: begin
        if (zero) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= 1'b0;
      dir_q       <= 1'b0;
      last_axis_q <= AXIS_PHI;
      last_dir_q  <= 1'b0;
      theta_q     <= W'(THETA_INIT);
      phi_q       <= W'(PHI_INIT);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      if (step_done) begin
        last_axis_q <= sel_q;
        last_dir_q  <= dir_q;
        if (sel_q == AXIS_THETA) begin
          theta_q <= dir_q ? theta_q + W'(1) : theta_q - W'(1);
        end else if (dir_q) begin
          phi_q <= (phi_q == W'(PHI_MAX)) ? '0 : phi_q + W'(1);
        end else begin
          phi_q <= (phi_q == '0) ? W'(PHI_MAX) : phi_q - W'(1);
        end
      end
    end
  end

  assign drv_step     = (state_q == StHigh);
  assign drv_sel      = sel_q;
  assign drv_dir      = dir_q;
  assign busy         = (state_q != StIdle);
  assign theta_limit  = theta_blocked;
  assign theta_actual = theta_q;
  assign phi_actual   = phi_q;

endmodule

// File: tb/tb_motor_step_scheduler.sv
// Self-checking bench: directed scenarios plus randomized requests against a
// cycle-count model of the step schedule.
module tb_motor_step_scheduler;

  localparam int SETUP = 2;
  localparam int PULSE = 3;
  localparam int STEP  = 10;
  localparam int TMAX  = 180;
  localparam int PMAX  = 359;
  localparam logic [1:0] ON = 2'b01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  tp = '0, tn = '0, pp = '0, pn = '0;
  logic        drv_step, drv_dir, drv_sel, busy, theta_limit;
  logic [15:0] theta_actual, phi_actual;

  int checks = 0;
  int errors = 0;

  motor_step_scheduler #(
    .W(16), .SETUP_CYC(SETUP), .PULSE_CYC(PULSE), .STEP_CYC(STEP),
    .THETA_MAX(TMAX), .PHI_MAX(PMAX), .THETA_INIT(90), .PHI_INIT(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_theta_pos(tp),
    .req_theta_neg(tn),
    .req_phi_pos  (pp),
    .req_phi_neg  (pn),
    .drv_step     (drv_step),
    .drv_dir      (drv_dir),
    .drv_sel      (drv_sel),
    .busy         (busy),
    .theta_limit  (theta_limit),
    .theta_actual (theta_actual),
    .phi_actual   (phi_actual)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an operation is a numbered run of cycles after the grant:
  // cycles 1..setup settle, then PULSE high cycles, then low until cycle setup+STEP-1.
  int m_th = 90, m_ph = 0, m_k = 0, m_setup = 0;
  bit m_last_axis = 1'b1, m_last_dir = 1'b0, m_act = 1'b0, m_axis = 1'b0, m_dir = 1'b0;

  function automatic void decode(input logic [1:0] p, input logic [1:0] n,
                                 output bit valid, output bit pos);
    valid = (p == ON) != (n == ON);
    pos   = (p == ON);
  endfunction

  initial forever begin
    bit tv, td, pv, pd, tok, still, exp_limit, exp_step;
    @(negedge clk);
    if (!rst_n) begin
      m_th = 90; m_ph = 0; m_last_axis = 1'b1; m_last_dir = 1'b0;
      m_act = 1'b0; m_k = 0; m_axis = 1'b0; m_dir = 1'b0;
    end
    decode(tp, tn, tv, td);
    decode(pp, pn, pv, pd);
    exp_limit = tv && ((td && m_th == TMAX) || (!td && m_th == 0));
    tok       = tv && !exp_limit;
    exp_step  = m_act && m_k > m_setup && m_k <= m_setup + PULSE;
    chk("drv_step", drv_step, exp_step);
    chk("busy", busy, m_act);
    chk("drv_sel", drv_sel, m_axis);
    chk("drv_dir", drv_dir, m_dir);
    chk("theta_limit", theta_limit, exp_limit);
    chk("theta_actual", theta_actual, m_th);
    chk("phi_actual", phi_actual, m_ph);
    if (rst_n) begin
      if (!m_act) begin
        if (tok || pv) begin
          m_axis  = (tok && pv) ? !m_last_axis : pv;
          m_dir   = m_axis ? pd : td;
          m_setup = (m_axis == m_last_axis && m_dir == m_last_dir) ? 0 : SETUP;
          m_act   = 1'b1;
          m_k     = 1;
        end
      end else if (m_k <= m_setup) begin
        still = m_axis ? (pv && pd == m_dir) : (tok && td == m_dir);
        if (still) m_k++;
        else m_act = 1'b0;
      end else if (m_k == m_setup + PULSE) begin
        if (!m_axis) m_th = m_dir ? m_th + 1 : m_th - 1;
        else m_ph = m_dir ? (m_ph + 1) % (PMAX + 1) : (m_ph + PMAX) % (PMAX + 1);
        m_last_axis = m_axis;
        m_last_dir  = m_dir;
        m_k++;
      end else if (m_k == m_setup + STEP - 1) begin
        m_act = 1'b0;
      end else begin
        m_k++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input logic lvl, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (drv_step === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name, input int max);
    int ok = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  function automatic logic [1:0] rnd_req();
    case ($urandom_range(0, 7))
      0, 1:    return 2'b00;
      5:       return 2'b10;
      6:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  initial begin
    int n, n2, cnt, phi0;
    logic [2:0] sels;
    tick();
    tick();
    chk("reset_step", drv_step, 0);
    chk("reset_busy", busy, 0);
    chk("reset_theta", theta_actual, 90);
    chk("reset_phi", phi_actual, 0);
    rst_n = 1'b1;
    tick();

    // Held theta+: first step needs setup, then fixed width and period.
    tp = ON;
    wait_level(1'b1, 20, n);
    chk("first_latency", n, 3);
    wait_level(1'b0, 20, n);
    chk("pulse_width", n, 3);
    chk("theta_first", theta_actual, 91);
    wait_level(1'b1, 20, n2);
    chk("step_period", n + n2, 10);
    repeat (25) tick();
    tp = '0;
    wait_idle("s1_idle", 30);

    // Both axes: phi wins the tie after theta, then alternation.
    tp = ON;
    pn = ON;
    for (int j = 0; j < 3; j++) begin
      wait_level(1'b1, 40, n);
      sels[j] = drv_sel;
      if (j == 2) begin
        tp = '0;
        pn = '0;
      end else begin
        wait_level(1'b0, 20, n);
        if (j == 0) chk("phi_wrap_359", phi_actual, 359);
      end
    end
    wait_idle("s2_idle", 30);
    chk("alt_sel0", sels[0], 1);
    chk("alt_sel1", sels[1], 0);
    chk("alt_sel2", sels[2], 1);
    chk("phi_358", phi_actual, 358);

    // Climb to the theta limit, then back off one step.
    tp = ON;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (theta_actual == 16'(TMAX)) break;
    end
    chk("theta_reach_max", theta_actual, TMAX);
    repeat (25) tick();
    chk("limit_flag", theta_limit, 1);
    chk("limit_no_busy", busy, 0);
    chk("limit_hold", theta_actual, TMAX);
    tp = '0;
    tn = ON;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (theta_actual == 16'(TMAX - 1)) begin
        n = 1;
        break;
      end
    end
    chk("theta_179", n, 1);
    chk("limit_clear", theta_limit, 0);
    tn = '0;
    wait_idle("s3_idle", 30);

    // Phi+ dropped in setup aborts; dropped in high still steps.
    phi0 = phi_actual;
    pp = ON;
    tick();
    chk("setup_busy", busy, 1);
    chk("setup_nostep", drv_step, 0);
    pp = '0;
    tick();
    tick();
    chk("abort_idle", busy, 0);
    chk("abort_phi", phi_actual, phi0);
    pp = ON;
    wait_level(1'b1, 20, n);
    pp = '0;
    wait_idle("s4_idle", 30);
    chk("high_drop_phi", phi_actual, (phi0 + 1) % (PMAX + 1));

    // Reset in the middle of a pulse.
    tp = ON;
    wait_level(1'b1, 20, n);
    rst_n = 1'b0;
    #1;
    chk("rst_step", drv_step, 0);
    chk("rst_busy", busy, 0);
    chk("rst_theta", theta_actual, 90);
    tp = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Ambiguous phi requests never start a step.
    pp = ON;
    pn = ON;
    cnt = 0;
    repeat (30) begin
      tick();
      if (busy) cnt++;
    end
    pn = '0;
    pp = 2'b11;
    repeat (30) begin
      tick();
      if (busy) cnt++;
    end
    chk("phi_ambiguous_idle", cnt, 0);
    chk("phi_ambiguous_pos", phi_actual, 0);
    pp = '0;

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        tp = rnd_req();
        tn = rnd_req();
        pp = rnd_req();
        pn = rnd_req();
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst_n = 1'b1;
    tp = '0;
    tn = '0;
    pp = '0;
    pn = '0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
